// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// Execute-side partner of the fetch-stage branch predictor. Every cycle the
// E-stage icode is inspected; a conditional/unconditional jump (icode 4'h7)
// has its fetch-time prediction compared with the resolved condition from
// execute. A wrong guess raises a one-cycle registered redirect carrying the
// correct next PC (aligned with the M stage). Every resolved jump, right or
// wrong, is also queued into a small FIFO. That FIFO drains to the predictor's
// training port over a valid/ready handshake. Saturating statistics counters
// track branches, mispredicts and (optionally) taken branches.
//
// Optional feature macro: BR_TAKEN_CNT_EN
//   defined   -> taken_count_o counts resolved-taken branches (saturating)
//   undefined -> no taken counter is built; taken_count_o is tied to 0
//
// Parameters:
//   ADDR_W     width of PC / target fields
//   FIFO_DEPTH update-queue entries (power of two, >= 2)
//   CNT_W      width of statistics counters
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   E_icode_i            E-stage icode (bubble = nop 4'h1)
//   E_PC_i               PC of the E-stage instruction
//   E_valC_i             jump target
//   E_valA_i             fall-through address (valP carried in valA)
//   E_branch_taken_i     prediction made at fetch
//   e_Cnd_i              resolved condition from execute
//   mispredict_o         one-cycle redirect pulse
//   redirect_PC_o        correct next PC while mispredict_o=1
//   upd_valid_o          training FIFO head valid
//   upd_PC_o             head branch PC
//   upd_taken_o          head resolved outcome
//   upd_ready_i          predictor accepts head
//   fifo_level_o         FIFO occupancy
//   drop_o               sticky: an update was lost to a full FIFO
//   branch_count_o       resolved jump count
//   mis_count_o          mispredict count
//   taken_count_o        resolved-taken count (optional feature)
// -----------------------------------------------------------------------------
module branch_resolver #(
  parameter int ADDR_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [3:0]                      E_icode_i,
  input  logic [ADDR_W-1:0]               E_PC_i,
  input  logic [ADDR_W-1:0]               E_valC_i,
  input  logic [ADDR_W-1:0]               E_valA_i,
  input  logic                            E_branch_taken_i,
  input  logic                            e_Cnd_i,
  output logic                            mispredict_o,
  output logic [ADDR_W-1:0]               redirect_PC_o,
  output logic                            upd_valid_o,
  output logic [ADDR_W-1:0]               upd_PC_o,
  output logic                            upd_taken_o,
  input  logic                            upd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            drop_o,
  output logic [CNT_W-1:0]                branch_count_o,
  output logic [CNT_W-1:0]                mis_count_o,
  output logic [CNT_W-1:0]                taken_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] ICODE_JXX = 4'h7;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Resolve-side decode
  logic seen;
  logic mis_hit;

  assign seen    = (E_icode_i == ICODE_JXX);
  assign mis_hit = seen && (e_Cnd_i ^ E_branch_taken_i);

  // Redirect state
  logic              mispredict_q, mispredict_d;
  logic [ADDR_W-1:0] redirect_q,   redirect_d;

  // Training FIFO state. Entries hold {PC, outcome}; the storage itself is
  // pure data and needs no reset because upd_valid_o masks stale contents.
  logic [ADDR_W:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q,  level_d;
  logic              drop_q,   drop_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic lost;

  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && upd_ready_i;
  // A pop on the same edge frees the slot, so a full queue can still accept.
  assign push  = seen && (!full || pop);
  assign lost  = seen && full && !pop;

  // Statistics counters
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q,    mis_cnt_d;

  always_comb begin
    mispredict_d = mis_hit;
    redirect_d   = redirect_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    drop_d       = drop_q;
    branch_cnt_d = branch_cnt_q;
    mis_cnt_d    = mis_cnt_q;

    // The redirect target is the path the predictor did not choose.
    if (mis_hit) begin
      redirect_d = e_Cnd_i ? E_valC_i : E_valA_i;
    end

    // Pointers wrap naturally since the depth is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (lost) begin
      drop_d = 1'b1;
    end

    if (seen) begin
      branch_cnt_d = sat_inc(branch_cnt_q);
    end
    if (mis_hit) begin
      mis_cnt_d = sat_inc(mis_cnt_q);
    end
  end

  // Resolve / queue-control stage boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_q       <= 1'b0;
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      drop_q       <= drop_d;
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {E_PC_i, e_Cnd_i};
    end
  end

`ifdef BR_TAKEN_CNT_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (seen && e_Cnd_i) begin
      taken_cnt_d = sat_inc(taken_cnt_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      taken_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign taken_count_o = taken_cnt_q;
`else
  assign taken_count_o = '0;
`endif

  // Output mapping; head fields read as zero while the queue is empty.
  logic [ADDR_W:0] head;

  assign head           = mem_q[rd_ptr_q];
  assign mispredict_o   = mispredict_q;
  assign redirect_PC_o  = redirect_q;
  assign upd_valid_o    = !empty;
  assign upd_PC_o       = empty ? '0 : head[ADDR_W:1];
  assign upd_taken_o    = empty ? 1'b0 : head[0];
  assign fifo_level_o   = level_q;
  assign drop_o         = drop_q;
  assign branch_count_o = branch_cnt_q;
  assign mis_count_o    = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  localparam int AW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    icode;
  logic [AW-1:0] pc, valc, vala;
  logic          btaken, cnd;
  logic          mis;
  logic [AW-1:0] redir;
  logic          uvalid;
  logic [AW-1:0] upc;
  logic          utaken;
  logic          uready;
  logic [LW-1:0] level;
  logic          drop;
  logic [CW-1:0] bcnt, mcnt, tcnt;

  always #5 clk = ~clk;

  branch_resolver #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .E_icode_i(icode), .E_PC_i(pc), .E_valC_i(valc), .E_valA_i(vala),
    .E_branch_taken_i(btaken), .e_Cnd_i(cnd),
    .mispredict_o(mis), .redirect_PC_o(redir),
    .upd_valid_o(uvalid), .upd_PC_o(upc), .upd_taken_o(utaken),
    .upd_ready_i(uready), .fifo_level_o(level), .drop_o(drop),
    .branch_count_o(bcnt), .mis_count_o(mcnt), .taken_count_o(tcnt)
  );

  int nchk = 0;
  int nfail = 0;

  // Reference model: queue of pending updates plus plain integer statistics.
  logic [AW-1:0] mq_pc[$];
  logic          mq_tk[$];
  logic          m_mis;
  logic [AW-1:0] m_redir;
  logic          m_drop;
  int            m_b, m_m, m_t;

  task automatic model_reset();
    mq_pc.delete();
    mq_tk.delete();
    m_mis = 1'b0; m_redir = '0; m_drop = 1'b0;
    m_b = 0; m_m = 0; m_t = 0;
  endtask

  // Advance the model by one clock edge given the inputs now applied.
  task automatic model_step();
    logic [AW-1:0] dpc;
    logic          dtk;
    if (mq_pc.size() > 0 && uready) begin
      dpc = mq_pc.pop_front();
      dtk = mq_tk.pop_front();
    end
    m_mis = 1'b0;
    if (icode == 4'h7) begin
      if (mq_pc.size() < DEPTH) begin
        mq_pc.push_back(pc);
        mq_tk.push_back(cnd);
      end else begin
        m_drop = 1'b1;
      end
      if (m_b < CMAX) m_b++;
      if (cnd != btaken) begin
        m_mis = 1'b1;
        m_redir = cnd ? valc : vala;
        if (m_m < CMAX) m_m++;
      end
      if (cnd && m_t < CMAX) m_t++;
    end
  endtask

  function automatic int exp_taken(input int t);
`ifdef BR_TAKEN_CNT_EN
    return t;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [AW-1:0] p, input logic [AW-1:0] c,
                        input logic [AW-1:0] a, input logic tk, input logic cd);
    icode = 4'h7; pc = p; valc = c; vala = a; btaken = tk; cnd = cd;
  endtask

  task automatic set_bubble();
    icode = 4'h1;
    pc = {$urandom, $urandom}; valc = {$urandom, $urandom}; vala = {$urandom, $urandom};
    btaken = 1'($urandom); cnd = 1'($urandom);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; uready = 1'b0; set_bubble();
    model_reset();
    @(posedge clk);
    #1;
    nchk++;
    if ({mis, redir, uvalid, upc, utaken, level, drop, bcnt, mcnt, tcnt} !== '0) begin
      nfail++;
      $display("FAIL reset_state: got mis=%0b redir=%h valid=%0b pc=%h level=%0d drop=%0b b=%0d m=%0d t=%0d, expected all zero",
               mis, redir, uvalid, upc, level, drop, bcnt, mcnt, tcnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_midop();
    apply_reset();
    uready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_br(AW'(64'h500 + 4 * i), 64'h900, 64'h904, 1'b0, 1'b1);
      tick();
    end
    set_bubble();
    nchk++;
    if (level !== LW'(3) || mis !== 1'b1) begin
      nfail++;
      $display("FAIL midop_setup: got level=%0d mis=%0b, expected level=3 mis=1", level, mis);
    end
    #3;
    rst = 1'b1;
    #1;
    nchk++;
    if ({mis, redir, uvalid, upc, utaken, level, drop, bcnt, mcnt, tcnt} !== '0) begin
      nfail++;
      $display("FAIL midop_reset: got mis=%0b redir=%h valid=%0b pc=%h level=%0d b=%0d m=%0d t=%0d, expected all zero",
               mis, redir, uvalid, upc, level, bcnt, mcnt, tcnt);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_correct_pred();
    apply_reset();
    uready = 1'b0;
    set_br(64'h40, 64'h80, 64'h4A, 1'b1, 1'b1);
    tick();
    nchk++;
    if ({mis, uvalid, upc, utaken} !== {1'b0, 1'b1, 64'h40, 1'b1}) begin
      nfail++;
      $display("FAIL correct_pred_head: got mis=%0b valid=%0b pc=%h taken=%0b, expected 0 1 40 1",
               mis, uvalid, upc, utaken);
    end
    nchk++;
    if (bcnt !== 8'd1 || mcnt !== 8'd0) begin
      nfail++;
      $display("FAIL correct_pred_counts: got b=%0d m=%0d, expected b=1 m=0", bcnt, mcnt);
    end
  endtask

  task automatic test_mispredict();
    apply_reset();
    uready = 1'b1;
    set_br(64'h48, 64'h100, 64'h4A, 1'b0, 1'b1);
    tick();
    nchk++;
    if (mis !== 1'b1 || redir !== 64'h100) begin
      nfail++;
      $display("FAIL mis_nt_to_t: got mis=%0b redir=%h, expected 1 100", mis, redir);
    end
    set_br(64'h48, 64'h100, 64'h4A, 1'b1, 1'b0);
    tick();
    nchk++;
    if (mis !== 1'b1 || redir !== 64'h4A) begin
      nfail++;
      $display("FAIL mis_t_to_nt: got mis=%0b redir=%h, expected 1 4a", mis, redir);
    end
    set_bubble();
    tick();
    nchk++;
    if (mis !== 1'b0 || redir !== 64'h4A || mcnt !== 8'd2 || bcnt !== 8'd2) begin
      nfail++;
      $display("FAIL mis_pulse_end: got mis=%0b redir=%h m=%0d b=%0d, expected 0 4a 2 2",
               mis, redir, mcnt, bcnt);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    uready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_br(AW'(64'h200 + 4 * i), 64'h0, 64'h0, 1'b1, 1'b1);
      tick();
    end
    nchk++;
    if (level !== LW'(4) || drop !== 1'b1 || bcnt !== 8'd5) begin
      nfail++;
      $display("FAIL overflow_state: got level=%0d drop=%0b b=%0d, expected 4 1 5", level, drop, bcnt);
    end
    set_bubble();
    uready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (uvalid !== 1'b1 || upc !== AW'(64'h200 + 4 * i)) begin
        nfail++;
        $display("FAIL overflow_drain%0d: got valid=%0b pc=%h, expected 1 %h",
                 i, uvalid, upc, 64'h200 + 4 * i);
      end
      tick();
    end
    nchk++;
    if (uvalid !== 1'b0 || level !== LW'(0) || drop !== 1'b1) begin
      nfail++;
      $display("FAIL overflow_empty: got valid=%0b level=%0d drop=%0b, expected 0 0 1", uvalid, level, drop);
    end
  endtask

  task automatic test_full_pushpop();
    logic [AW-1:0] order [4];
    order = '{64'h304, 64'h308, 64'h30C, 64'h340};
    apply_reset();
    uready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_br(AW'(64'h300 + 4 * i), 64'h0, 64'h0, 1'b0, 1'b0);
      tick();
    end
    set_br(64'h340, 64'h0, 64'h0, 1'b1, 1'b1);
    uready = 1'b1;
    tick();
    nchk++;
    if (level !== LW'(4) || drop !== 1'b0) begin
      nfail++;
      $display("FAIL pushpop_level: got level=%0d drop=%0b, expected 4 0", level, drop);
    end
    set_bubble();
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (uvalid !== 1'b1 || upc !== order[i]) begin
        nfail++;
        $display("FAIL pushpop_order%0d: got valid=%0b pc=%h, expected 1 %h", i, uvalid, upc, order[i]);
      end
      tick();
    end
  endtask

  task automatic test_bubbles_taken();
    apply_reset();
    uready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_br(AW'(64'h600 + 4 * i), 64'h0, 64'h0, 1'b1, 1'b1);
      else       set_br(AW'(64'h600 + 4 * i), 64'h0, 64'h0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      set_bubble();
      tick();
    end
    nchk++;
    if (bcnt !== 8'd5 || mcnt !== 8'd0 || mis !== 1'b0) begin
      nfail++;
      $display("FAIL bubble_counts: got b=%0d m=%0d mis=%0b, expected 5 0 0", bcnt, mcnt, mis);
    end
    nchk++;
    if (tcnt !== CW'(exp_taken(3))) begin
      nfail++;
      $display("FAIL taken_count: got %0d, expected %0d", tcnt, exp_taken(3));
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    uready = 1'b1;
    for (int i = 0; i < CMAX + 5; i++) begin
      set_br(AW'(i), 64'hA0, 64'hB0, 1'b0, 1'b1);
      tick();
    end
    nchk++;
    if (bcnt !== CW'(CMAX) || mcnt !== CW'(CMAX) || tcnt !== CW'(exp_taken(CMAX))) begin
      nfail++;
      $display("FAIL saturation: got b=%0d m=%0d t=%0d, expected %0d %0d %0d",
               bcnt, mcnt, tcnt, CMAX, CMAX, exp_taken(CMAX));
    end
    nchk++;
    if (drop !== 1'b0) begin
      nfail++;
      $display("FAIL saturation_drop: got %0b, expected 0", drop);
    end
  endtask

  task automatic test_random_traffic();
    int r;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        set_br({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom), 1'($urandom));
      end else if (r == 6) begin
        set_bubble();
      end else begin
        set_bubble();
        icode = 4'($urandom);
      end
      uready = (cyc < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      nchk++;
      if (mis !== m_mis || redir !== m_redir) begin
        nfail++;
        $display("FAIL rand_redirect c%0d: got mis=%0b redir=%h, expected %0b %h", cyc, mis, redir, m_mis, m_redir);
      end
      nchk++;
      if (uvalid !== (mq_pc.size() > 0) || level !== LW'(mq_pc.size()) || drop !== m_drop) begin
        nfail++;
        $display("FAIL rand_queue c%0d: got valid=%0b level=%0d drop=%0b, expected %0b %0d %0b",
                 cyc, uvalid, level, drop, mq_pc.size() > 0, mq_pc.size(), m_drop);
      end
      nchk++;
      if (bcnt !== CW'(m_b) || mcnt !== CW'(m_m) || tcnt !== CW'(exp_taken(m_t))) begin
        nfail++;
        $display("FAIL rand_counts c%0d: got b=%0d m=%0d t=%0d, expected %0d %0d %0d",
                 cyc, bcnt, mcnt, tcnt, m_b, m_m, exp_taken(m_t));
      end
      if (mq_pc.size() > 0) begin
        nchk++;
        if (upc !== mq_pc[0] || utaken !== mq_tk[0]) begin
          nfail++;
          $display("FAIL rand_head c%0d: got pc=%h taken=%0b, expected %h %0b",
                   cyc, upc, utaken, mq_pc[0], mq_tk[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct_pred();
    test_mispredict();
    test_overflow();
    test_full_pushpop();
    test_bubbles_taken();
    test_reset_midop();
    test_saturation();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
